// File: rtl/fifo_set_seq.sv
// fifo_set_seq: bank-load then skewed-shift sequencer for systolic FIFO feeders
module fifo_set_seq #(
    parameter int NUM_FIFOS    = 8,
    parameter int DEPTH        = 8,
    parameter int DRAIN_CYCLES = 8,
    parameter int CNT_W        = $clog2(DEPTH + NUM_FIFOS + DRAIN_CYCLES) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stall,
    output logic [NUM_FIFOS-1:0] wr_en,
    output logic [NUM_FIFOS-1:0] shift_en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     step
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH + NUM_FIFOS - 2);
    localparam logic [CNT_W-1:0] DLAST = CNT_W'(DRAIN_CYCLES == 0 ? 0 : DRAIN_CYCLES - 1);
    state_t           r_state, w_nstate;
    logic [CNT_W-1:0] r_step, w_nstep;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_nstate;
            r_step  <= w_nstep;
        end
    end
    always_comb begin
        w_nstate = r_state;
        w_nstep  = r_step;
        case (r_state)
            IDLE:  w_nstate = start ? LOAD : IDLE;
            LOAD: begin
                w_nstate = RUN;
                w_nstep  = '0;
            end
            RUN: if (!stall) begin
                w_nstate = r_step == LAST ? (DRAIN_CYCLES == 0 ? DONE : DRAIN) : RUN;
                w_nstep  = r_step == LAST ? '0 : r_step + CNT_W'(1);
            end
            DRAIN: if (!stall) begin
                w_nstate = r_step == DLAST ? DONE : DRAIN;
                w_nstep  = r_step == DLAST ? '0 : r_step + CNT_W'(1);
            end
            default: begin
                w_nstate = IDLE;
                w_nstep  = '0;
            end
        endcase
    end
    // wrapped difference exceeds DEPTH-1 whenever step < i, so one compare covers the window
    always_comb begin
        shift_en = '0;
        for (int i = 0; i < NUM_FIFOS; i++)
            shift_en[i] = (r_state == RUN) && !stall && ((r_step - CNT_W'(i)) < CNT_W'(DEPTH));
    end
    assign wr_en = {NUM_FIFOS{r_state == LOAD}};
    assign busy  = r_state != IDLE;
    assign done  = r_state == DONE;
    assign step  = r_step;
endmodule
